ysyx_25010008_xbar: RTL

YSYX_25010008_XBAR -- requirements
Module: ysyx_25010008_XBAR
Role: AXI4-Lite read-channel router between one master (IFU/LSU) and two slaves (CLINT, main memory); one outstanding read.

---
 rtl/ysyx_25010008_xbar.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ysyx_25010008_xbar.sv
// AXI4-Lite read-channel router: one master to CLINT and main memory, one outstanding read.
// Define YSYX_25010008_XBAR_DECERR_EN to answer unmapped addresses with DECERR instead of memory.
module ysyx_25010008_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_SIZE = 32'h0001_0000,
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0800_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic [31:0] clint_araddr,
  output logic        clint_arvalid,
  input  logic        clint_arready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic        clint_rvalid,
  output logic        clint_rready,
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StErr} state_e;

  // Window ends are 33 bits so a window touching 2^32 cannot wrap.
  localparam logic [32:0] ClintEnd = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
  localparam logic [32:0] MemEnd   = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  state_e      state_q, state_d;
  logic        sel_clint_q, sel_clint_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rvalid_q, rvalid_d;
  logic        arready_q, arready_d;

  logic        hit_clint;
  logic        slv_arready;
  logic        slv_rvalid;
  logic [31:0] slv_rdata;
  logic [1:0]  slv_rresp;

  assign hit_clint = ({1'b0, araddr} >= {1'b0, CLINT_BASE}) && ({1'b0, araddr} < ClintEnd);

`ifdef YSYX_25010008_XBAR_DECERR_EN
  logic hit_mem;
  assign hit_mem = ({1'b0, araddr} >= {1'b0, MEM_BASE}) && ({1'b0, araddr} < MemEnd);
`else
  // Without DECERR every non-CLINT address goes to memory, so the memory window is not decoded.
  logic [32:0] mem_end_unused;
  assign mem_end_unused = MemEnd;
`endif

  assign slv_arready = sel_clint_q ? clint_arready : mem_arready;
  assign slv_rvalid  = sel_clint_q ? clint_rvalid  : mem_rvalid;
  assign slv_rdata   = sel_clint_q ? clint_rdata   : mem_rdata;
  assign slv_rresp   = sel_clint_q ? clint_rresp   : mem_rresp;

  always_comb begin
    state_d     = state_q;
    sel_clint_d = sel_clint_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rvalid_d    = rvalid_q;
    arready_d   = arready_q;
    unique case (state_q)
      StIdle: begin
        if (arvalid) begin
          addr_d      = araddr;
          sel_clint_d = hit_clint;
          arready_d   = 1'b0;
`ifdef YSYX_25010008_XBAR_DECERR_EN
          state_d     = (hit_clint || hit_mem) ? StAddr : StErr;
`else
          state_d     = StAddr;
`endif
        end
      end
      StAddr: begin
        if (slv_arready) state_d = StData;
      end
      StData: begin
        if (slv_rvalid) begin
          rdata_d  = slv_rdata;
          rresp_d  = slv_rresp;
          rvalid_d = 1'b1;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StErr: begin
        // Fabricate the DECERR beat, then share the RESP hold/handshake path.
        rdata_d  = 32'h0;
        rresp_d  = 2'b11;
        rvalid_d = 1'b1;
        state_d  = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      sel_clint_q <= 1'b0;
      addr_q      <= 32'h0;
      rdata_q     <= 32'h0;
      rresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      arready_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      sel_clint_q <= sel_clint_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rvalid_q    <= rvalid_d;
      arready_q   <= arready_d;
    end
  end

  assign arready       = arready_q;
  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign rresp         = rresp_q;
  assign clint_araddr  = addr_q;
  assign mem_araddr    = addr_q;
  assign clint_arvalid = (state_q == StAddr) &&  sel_clint_q;
  assign mem_arvalid   = (state_q == StAddr) && !sel_clint_q;
  assign clint_rready  = (state_q == StData) &&  sel_clint_q;
  assign mem_rready    = (state_q == StData) && !sel_clint_q;

endmodule
